mor_acc: RTL and testbench
==========================

MOR_ACC -- requirements
Module: mor_acc

Interface
REQ-001 SHALL provide parameter UUID, default 0, an instance identifier XORed into every child UUID.
REQ-002 SHALL provide parameter NAME, default "", an instance label with no functional effect.
REQ-003 SHALL provide parameter BIT_WIDTH, default 16, the data word width (legal range 1..64).
REQ-004 SHALL provide parameter BEATS, default 4, the words OR-accumulated per frame (legal range 1..255); CNT_W = clog2(BEATS+1).
REQ-005 SHALL provide port clk  input  1  sole clock, with all state updated on its rising edge.
REQ-006 SHALL provide port rst  input  1  synchronous active-high reset.
REQ-007 SHALL provide port In_data  input  BIT_WIDTH  input word.
REQ-008 SHALL provide port In_valid  input  1  input word present.
REQ-009 SHALL provide port In_ready  output  1  block accepts a word this cycle.
REQ-010 SHALL provide port Out_data  output  BIT_WIDTH  accumulator register value.
REQ-011 SHALL provide port Out_valid  output  1  completed frame result present.
REQ-012 SHALL provide port Out_ready  input  1  consumer takes the result.
REQ-013 SHALL provide port Out_count  output  CNT_W  beats accumulated in the current or held frame.
REQ-014 SHALL provide port Flush  input  1  early frame close, present only under MOR_ACC_FLUSH_EN.

Function
REQ-015 SHALL implement two states: ACCUM (In_ready=1, Out_valid=0) and HOLD (In_ready=0, Out_valid=1).
REQ-016 SHALL accept a word in ACCUM when In_valid=1: acc <= (cnt==0 ? In_data : acc | In_data), cnt <= cnt+1.
REQ-017 SHALL enter HOLD on the cycle that accepts the word making cnt equal BEATS; Out_valid rises on the next cycle (1-cycle latency from last accept).
REQ-018 SHALL drive Out_data = acc register and Out_count = cnt in every state, including partial values during ACCUM.
REQ-019 SHALL in HOLD keep acc and cnt frozen until Out_valid & Out_ready, then return to ACCUM with cnt <= 0 (acc retained but overwritten by the next first beat).
REQ-020 SHALL NOT accept input on the same cycle as the output handshake, because In_ready=0 throughout HOLD.
REQ-021 SHALL ignore In_data and Out_ready whenever no handshake occurs, with no state change.
REQ-022 SHALL, when BEATS=1, move every accepted word directly to HOLD with Out_data equal to that word.
REQ-023 SHALL wrap or saturate no counter, since cnt never exceeds BEATS.

Reset
REQ-024 SHALL on rst=1 at a clock edge set state=ACCUM, acc=0, cnt=0, giving Out_valid=0, In_ready=1, Out_data=0, Out_count=0 on the next cycle.
REQ-025 SHALL give rst priority over all inputs, so a mid-frame or HOLD reset discards the frame without emitting it.

Configuration
REQ-026 SHALL, with macro MOR_ACC_FLUSH_EN defined, include Flush: in ACCUM, Flush=1 with (cnt>0 or a word accepted the same cycle) enters HOLD with the frame including that word and Out_count = beats so far.
REQ-027 SHALL, with MOR_ACC_FLUSH_EN defined, ignore Flush when cnt==0 with no accept, and in HOLD.
REQ-028 SHALL, without MOR_ACC_FLUSH_EN, omit the Flush port; frames close only at BEATS.

Verification
REQ-029 SHALL be verified for the basic frame: BIT_WIDTH=16, BEATS=4, words 0x0001,0x0010,0x0100,0x1000 back-to-back -> Out_valid=1 one cycle after the 4th accept, Out_data=0x1111, Out_count=4.
REQ-030 SHALL be verified for backpressure: Out_ready=0 for 5 cycles in HOLD with In_valid=1 -> In_ready=0, Out_data stays 0x1111, no words consumed; Out_ready=1 -> ACCUM next cycle, Out_count=0.
REQ-031 SHALL be verified for frame isolation: second frame 0x00F0,0,0,0 after the first -> Out_data=0x00F0, with no carry from the prior 0x1111.
REQ-032 SHALL be verified for mid-frame reset: rst after 2 accepts (0xAAAA,0x5555) -> next cycle Out_data=0, Out_count=0, Out_valid=0; the next 4 words form a clean frame.
REQ-033 SHALL be verified for flush (MOR_ACC_FLUSH_EN): accept 0x0003, then 0x0300 with Flush=1 -> HOLD with Out_data=0x0303, Out_count=2; Flush with cnt=0 and In_valid=0 -> no change.
REQ-034 SHALL be verified for the edge case: BEATS=1, In_data=0xBEEF -> Out_valid=1 next cycle, Out_data=0xBEEF, Out_count=1.

Source files
------------

// File: rtl/mor_acc.sv
// mor_acc: OR-accumulates BEATS input words into one frame result and holds it until consumed.
// Build option: define MOR_ACC_FLUSH_EN to add the Flush early frame-close input.
module mor_acc #(
  parameter int UUID      = 0,
  parameter     NAME      = "",
  parameter int BIT_WIDTH = 16,
  parameter int BEATS     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BIT_WIDTH-1:0]         In_data,
  input  logic                         In_valid,
  output logic                         In_ready,
  output logic [BIT_WIDTH-1:0]         Out_data,
  output logic                         Out_valid,
  input  logic                         Out_ready,
`ifdef MOR_ACC_FLUSH_EN
  input  logic                         Flush,
`endif
  output logic [$clog2(BEATS+1)-1:0]   Out_count
);

  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  // No child instances exist yet; identifiers are kept for hierarchy bookkeeping.
  localparam int unused_uuid = UUID;
  localparam     unused_name = NAME;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t               state;
  logic [BIT_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic                 flush_req;

`ifdef MOR_ACC_FLUSH_EN
  assign flush_req = Flush;
`else
  assign flush_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (In_valid) begin
            // First beat overwrites, so a finished frame never leaks into the next.
            acc <= (cnt == '0) ? In_data : (acc | In_data);
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST || flush_req)
              state <= HOLD;
          end else if (flush_req && cnt != '0) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (Out_ready) begin
            state <= ACCUM;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign In_ready  = (state == ACCUM);
  assign Out_valid = (state == HOLD);
  assign Out_data  = acc;
  assign Out_count = cnt;

endmodule

// File: tb/tb_mor_acc.sv
// tb_mor_acc: directed frames plus randomized traffic against a queue-based frame model.
module tb_mor_acc;
  localparam int W = 16;
  localparam int B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // BEATS=4 instance
  logic         rst, in_valid, out_ready, flush;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [2:0]   out_count;

  // BEATS=1 instance
  logic         rst1, in_valid1, out_ready1, flush1;
  logic [W-1:0] in_data1;
  logic         in_ready1, out_valid1;
  logic [W-1:0] out_data1;
  logic [0:0]   out_count1;

  mor_acc #(.UUID(1), .NAME("acc4"), .BIT_WIDTH(W), .BEATS(B)) dut (
    .clk(clk), .rst(rst),
    .In_data(in_data), .In_valid(in_valid), .In_ready(in_ready),
    .Out_data(out_data), .Out_valid(out_valid), .Out_ready(out_ready),
`ifdef MOR_ACC_FLUSH_EN
    .Flush(flush),
`endif
    .Out_count(out_count)
  );

  mor_acc #(.UUID(2), .NAME("acc1"), .BIT_WIDTH(W), .BEATS(1)) dut1 (
    .clk(clk), .rst(rst1),
    .In_data(in_data1), .In_valid(in_valid1), .In_ready(in_ready1),
    .Out_data(out_data1), .Out_valid(out_valid1), .Out_ready(out_ready1),
`ifdef MOR_ACC_FLUSH_EN
    .Flush(flush1),
`endif
    .Out_count(out_count1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Frame model: words of the open/held frame, hold flag, last visible accumulator.
  logic [W-1:0] q[$];
  bit           m_hold;
  logic [W-1:0] m_last;

  function automatic logic [W-1:0] or_all();
    logic [W-1:0] r = '0;
    foreach (q[i]) r |= q[i];
    return r;
  endfunction

  function automatic logic [W-1:0] m_data();
    return (q.size() != 0) ? or_all() : m_last;
  endfunction

  task automatic model_edge();
    if (rst) begin
      q.delete(); m_hold = 0; m_last = '0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_last = or_all(); q.delete(); m_hold = 0;
      end
    end else if (in_valid) begin
      q.push_back(in_data);
      if (q.size() == B || flush) m_hold = 1;
    end else if (flush && q.size() != 0) begin
      m_hold = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_rdy"},   64'(in_ready),  64'(!m_hold));
    chk({tag, "_vld"},   64'(out_valid), 64'(m_hold));
    chk({tag, "_data"},  64'(out_data),  64'(m_data()));
    chk({tag, "_count"}, 64'(out_count), 64'(q.size()));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic feed(input logic [W-1:0] d, input string tag);
    in_valid = 1'b1; in_data = d;
    step(tag);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] exp_or;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
    rst1 = 1'b1; in_valid1 = 1'b0; out_ready1 = 1'b0; flush1 = 1'b0; in_data1 = '0;
    q.delete(); m_hold = 0; m_last = '0;

    // Reset state
    step("reset");
    chk("reset_data", 64'(out_data), 64'h0);
    chk("reset_rdy", 64'(in_ready), 64'h1);
    rst = 1'b0; rst1 = 1'b0;

    // Basic frame
    feed(16'h0001, "f1"); feed(16'h0010, "f1"); feed(16'h0100, "f1"); feed(16'h1000, "f1");
    chk("basic_vld", 64'(out_valid), 64'h1);
    chk("basic_data", 64'(out_data), 64'h1111);
    chk("basic_count", 64'(out_count), 64'h4);

    // Backpressure: input offered while held must not be consumed
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = W'($urandom);
      step("bp");
      chk("bp_rdy", 64'(in_ready), 64'h0);
      chk("bp_data", 64'(out_data), 64'h1111);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step("bp_rel");
    out_ready = 1'b0;
    chk("bp_rel_vld", 64'(out_valid), 64'h0);
    chk("bp_rel_count", 64'(out_count), 64'h0);

    // Frame isolation
    feed(16'h00F0, "iso"); feed(16'h0000, "iso"); feed(16'h0000, "iso"); feed(16'h0000, "iso");
    chk("iso_data", 64'(out_data), 64'h00F0);
    out_ready = 1'b1; step("iso_drain"); out_ready = 1'b0;

    // Mid-frame reset discards partial frame
    feed(16'hAAAA, "mr"); feed(16'h5555, "mr");
    rst = 1'b1; step("mr_rst"); rst = 1'b0;
    chk("mr_data", 64'(out_data), 64'h0);
    chk("mr_count", 64'(out_count), 64'h0);
    chk("mr_vld", 64'(out_valid), 64'h0);
    exp_or = '0;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] d = W'($urandom);
      exp_or |= d;
      feed(d, "mr_frame");
    end
    chk("mr_frame_data", 64'(out_data), 64'(exp_or));
    out_ready = 1'b1; step("mr_drain"); out_ready = 1'b0;

`ifdef MOR_ACC_FLUSH_EN
    feed(16'h0003, "fl");
    flush = 1'b1; feed(16'h0300, "fl"); flush = 1'b0;
    chk("fl_vld", 64'(out_valid), 64'h1);
    chk("fl_data", 64'(out_data), 64'h0303);
    chk("fl_count", 64'(out_count), 64'h2);
    out_ready = 1'b1; step("fl_drain"); out_ready = 1'b0;
    flush = 1'b1; step("fl_idle"); flush = 1'b0;
    chk("fl_idle_vld", 64'(out_valid), 64'h0);
    chk("fl_idle_count", 64'(out_count), 64'h0);
`endif

    // BEATS=1 edge case
    in_valid1 = 1'b1; in_data1 = 16'hBEEF;
    step("b1");
    in_valid1 = 1'b0;
    chk("b1_vld", 64'(out_valid1), 64'h1);
    chk("b1_data", 64'(out_data1), 64'hBEEF);
    chk("b1_count", 64'(out_count1), 64'h1);
    chk("b1_rdy", 64'(in_ready1), 64'h0);
    out_ready1 = 1'b1; step("b1_drain"); out_ready1 = 1'b0;
    chk("b1_drain_vld", 64'(out_valid1), 64'h0);
    chk("b1_drain_rdy", 64'(in_ready1), 64'h1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      in_data   = W'($urandom);
      rst       = ($urandom_range(0, 49) == 0);
`ifdef MOR_ACC_FLUSH_EN
      flush     = ($urandom_range(0, 5) == 0);
`endif
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
